// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: loads a program into instruction RAM, then
// fetches one word per cycle with hazard stalls and branch redirects.
module fetch_sequencer #(
  parameter int IMEM_DEPTH = 1024,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_done,
  input  logic          hazard_stall,
  input  logic          br_taken,
  input  logic [31:0]   br_addr,
  output logic [AW-1:0] imem_addr,
  output logic          imem_we,
  output logic [31:0]   imem_wdata,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   pc_out,
  output logic [31:0]   instr_out,
  output logic          if_valid,
  output logic          flush,
  output logic          load_overflow,
  output logic [15:0]   fetch_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, STALL} state_t;

  localparam logic [AW:0] PTR_MAX = (AW+1)'(IMEM_DEPTH);

  state_t      state;
  logic [31:0] pc;
  logic [AW:0] load_ptr;
  logic        loading;
  logic        load_write;

  // The RAM port is shared: the loader owns it until execution starts.
  assign loading    = (state == IDLE) || (state == LOAD);
  assign load_write = loading && load_valid && (load_ptr != PTR_MAX);
  assign imem_we    = load_write && !rst;
  assign imem_wdata = load_data;
  assign imem_addr  = loading ? load_ptr[AW-1:0] : pc[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= 32'd0;
      load_ptr      <= '0;
      pc_out        <= 32'd0;
      instr_out     <= 32'd0;
      if_valid      <= 1'b0;
      flush         <= 1'b0;
      load_overflow <= 1'b0;
      fetch_count   <= 16'd0;
    end else begin
      flush <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (load_valid) begin
            if (load_ptr != PTR_MAX)
              load_ptr <= load_ptr + 1'b1;
            else
              load_overflow <= 1'b1;
          end
          if (load_done) begin
            state <= RUN;
            pc    <= 32'd0;
          end else if (load_valid) begin
            state <= LOAD;
          end
        end
        RUN, STALL: begin
          // A redirect overrides any stall request in the same cycle.
          if (br_taken) begin
            pc        <= br_addr;
            pc_out    <= 32'd0;
            instr_out <= 32'd0;
            if_valid  <= 1'b0;
            flush     <= 1'b1;
            state     <= RUN;
          end else if (state == STALL) begin
            if (!hazard_stall)
              state <= RUN;
          end else if (hazard_stall) begin
            state <= STALL;
          end else begin
            pc        <= pc + 32'd4;
            pc_out    <= pc + 32'd4;
            instr_out <= imem_rdata;
            if_valid  <= 1'b1;
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a behavioural
// model of loading, fetching, stalling and branching.
module tb_fetch_sequencer;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_done, hazard_stall, br_taken;
  logic [31:0] load_data, br_addr;
  logic [9:0]  imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata, imem_rdata, pc_out, instr_out;
  logic        if_valid, flush, load_overflow;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  fetch_sequencer #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
    .hazard_stall(hazard_stall), .br_taken(br_taken), .br_addr(br_addr),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .if_valid(if_valid),
    .flush(flush), .load_overflow(load_overflow), .fetch_count(fetch_count)
  );

  // Instruction RAM seen by the DUT
  logic [31:0] ram [DEPTH];
  assign imem_rdata = ram[imem_addr];
  always @(posedge clk) if (imem_we) ram[imem_addr] <= imem_wdata;

  // Behavioural model: mode 0 = accepting program words, 1 = fetching, 2 = frozen
  int          m_mode, m_ptr;
  logic [31:0] m_pc, m_pcout, m_instr;
  logic        m_valid, m_flush, m_ovf;
  logic [15:0] m_cnt;
  logic [31:0] ref_mem [DEPTH];
  logic        exp_we;

  int  n_cmp, n_bad;
  bit  check_en;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_pc = 0; m_pcout = 0; m_instr = 0;
      m_valid = 0; m_flush = 0; m_ovf = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_flush = 0;
      if (load_valid) begin
        if (m_ptr < DEPTH) begin
          ref_mem[m_ptr] = load_data;
          m_ptr++;
        end else m_ovf = 1;
      end
      if (load_done) begin m_mode = 1; m_pc = 0; end
    end else begin
      m_flush = 0;
      if (br_taken) begin
        m_pc = br_addr; m_pcout = 0; m_instr = 0; m_valid = 0; m_flush = 1; m_mode = 1;
      end else if (m_mode == 2) begin
        if (!hazard_stall) m_mode = 1;
      end else if (hazard_stall) begin
        m_mode = 2;
      end else begin
        m_instr = ref_mem[(m_pc / 4) % DEPTH];
        m_pc    = m_pc + 32'd4;
        m_pcout = m_pc;
        m_valid = 1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("pc_out", pc_out, m_pcout);
      checkOutput("instr_out", instr_out, m_instr);
      checkOutput("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      checkOutput("flush", {31'd0, flush}, {31'd0, m_flush});
      checkOutput("load_overflow", {31'd0, load_overflow}, {31'd0, m_ovf});
      checkOutput("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
      exp_we = !rst && (m_mode == 0) && load_valid && (m_ptr < DEPTH);
      checkOutput("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
      if (exp_we) begin
        checkOutput("imem_addr load", {22'd0, imem_addr}, m_ptr % DEPTH);
        checkOutput("imem_wdata", imem_wdata, load_data);
      end else if (m_mode != 0) begin
        checkOutput("imem_addr run", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
      end
    end
  end

  task automatic applyStimulus(input logic lv, input logic [31:0] ld, input logic ldone,
                               input logic hs, input logic bt, input logic [31:0] ba);
    load_valid = lv; load_data = ld; load_done = ldone;
    hazard_stall = hs; br_taken = bt; br_addr = ba;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tab [16];
  logic [31:0] first_w, last_w, rba;
  logic        rhs, rbt;

  initial begin
    n_cmp = 0; n_bad = 0; check_en = 0;
    load_valid = 0; load_data = 0; load_done = 0;
    hazard_stall = 0; br_taken = 0; br_addr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_en = 1;
    checkOutput("reset pc_out", pc_out, 32'd0);
    checkOutput("reset if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("reset fetch_count", {16'd0, fetch_count}, 32'd0);

    // Fill the whole RAM, then overrun it by one word
    first_w = $urandom;
    applyStimulus(1, first_w, 0, 0, 0, 0);
    for (int i = 1; i < DEPTH; i++) begin
      last_w = $urandom;
      applyStimulus(1, last_w, 0, 0, 0, 0);
    end
    load_valid = 1; load_data = 32'hBAD0BAD0;
    #1;
    checkOutput("overrun write blocked", {31'd0, imem_we}, 32'd0);
    @(posedge clk); #1;
    load_valid = 0;
    checkOutput("overflow sticky", {31'd0, load_overflow}, 32'd1);
    checkOutput("ram[0] after fill", ram[0], first_w);
    checkOutput("ram[1023] after fill", ram[1023], last_w);

    // Fresh program: three known words plus random filler
    rst = 1; applyStimulus(0, 0, 0, 0, 0, 0); rst = 0;
    checkOutput("overflow cleared", {31'd0, load_overflow}, 32'd0);
    tab[0] = 32'h80010601; tab[1] = 32'h90011000; tab[2] = 32'h0C011800;
    for (int i = 3; i < 16; i++) tab[i] = $urandom;
    for (int i = 0; i < 16; i++) applyStimulus(1, tab[i], 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("ram[0]", ram[0], 32'h80010601);
    checkOutput("ram[1]", ram[1], 32'h90011000);
    checkOutput("ram[2]", ram[2], 32'h0C011800);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("first fetch pc_out", pc_out, 32'd4);
    checkOutput("first fetch instr", instr_out, 32'h80010601);
    checkOutput("first fetch valid", {31'd0, if_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("second fetch pc_out", pc_out, 32'd8);

    // Three-cycle stall at PC=8
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("stall pc_out hold", pc_out, 32'd8);
      checkOutput("stall instr hold", instr_out, 32'h90011000);
      checkOutput("stall count hold", {16'd0, fetch_count}, 32'd2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stall release pc_out", pc_out, 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("resume pc_out", pc_out, 32'h0000000C);
    checkOutput("resume instr", instr_out, 32'h0C011800);
    checkOutput("resume count", {16'd0, fetch_count}, 32'd3);

    // Branch and stall together: branch wins
    applyStimulus(0, 0, 0, 1, 1, 32'h28);
    checkOutput("branch flush", {31'd0, flush}, 32'd1);
    checkOutput("branch if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("branch instr", instr_out, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("branch target pc_out", pc_out, 32'h2C);
    checkOutput("branch target instr", instr_out, tab[10]);
    checkOutput("flush one cycle", {31'd0, flush}, 32'd0);

    // Random traffic; loader inputs must be ignored while running
    for (int i = 0; i < 400; i++) begin
      rhs = ($urandom_range(0, 9) < 3);
      rbt = ($urandom_range(0, 9) == 0);
      rba = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, rhs, rbt, rba);
    end

    // Branch to the last word, then wrap
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFFFFFC);
    checkOutput("wrap branch addr", {22'd0, imem_addr}, 32'd1023);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("wrap pc_out", pc_out, 32'd0);
    checkOutput("wrap addr", {22'd0, imem_addr}, 32'd0);
    checkOutput("wrap instr", instr_out, last_w);

    // Reset in the middle of a load
    rst = 1; applyStimulus(0, 0, 0, 0, 0, 0); rst = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1, tab[i], 0, 0, 0, 0);
    rst = 1; applyStimulus(1, 32'h12345678, 0, 0, 0, 0); rst = 0;
    load_valid = 0;
    checkOutput("midload rst pc_out", pc_out, 32'd0);
    checkOutput("midload rst instr", instr_out, 32'd0);
    checkOutput("midload rst valid", {31'd0, if_valid}, 32'd0);
    checkOutput("midload rst count", {16'd0, fetch_count}, 32'd0);
    load_valid = 1; load_data = 32'hDEADBEEF;
    #1;
    checkOutput("reload we", {31'd0, imem_we}, 32'd1);
    checkOutput("reload addr", {22'd0, imem_addr}, 32'd0);
    @(posedge clk); #1;
    load_valid = 0;
    checkOutput("reload ram[0]", ram[0], 32'hDEADBEEF);
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      rhs = ($urandom_range(0, 9) < 2);
      rbt = ($urandom_range(0, 15) == 0);
      rba = {22'd0, 8'($urandom), 2'b00};
      applyStimulus(0, 0, 0, rhs, rbt, rba);
    end

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
